// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - boot byte stream and cpu fetch signal bundle
interface imem_loader_if #(
  parameter int width       = 16,
  parameter int iaddr_width = 10
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [iaddr_width-1:0] iaddr;
  logic [width-1:0]       idata;
  logic                   cpu_reset;
  logic                   load_done;
  logic                   load_err;

  modport master (
    output rx_data, rx_valid, iaddr,
    input  rx_ready, idata, cpu_reset, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid, iaddr,
    output rx_ready, idata, cpu_reset, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction RAM with byte-stream boot loader and checksum gate
module imem_loader #(
  parameter int width       = 16,
  parameter int iaddr_width = 10
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus
);
  localparam int          depth   = 1 << iaddr_width;
  localparam logic [16:0] depth_n = 17'(depth);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR
  } state_t;

  state_t                 state, state_next;
  logic [15:0]            n, n_next;
  logic [iaddr_width:0]   addr, addr_next;
  logic [iaddr_width:0]   addr_inc;
  logic [7:0]             csum, csum_next;
  logic [7:0]             hi, hi_next;
  logic [15:0]            n_rx;
  logic                   xfer;
  logic                   we;
  logic [width-1:0]       mem [depth];

  // The loader takes bytes in every loading state; RUN and ERROR are closed.
  assign bus.rx_ready = (state != RUN) && (state != ERROR);
  assign xfer         = bus.rx_valid & bus.rx_ready;
  assign n_rx         = {n[15:8], bus.rx_data};
  // One extra address bit lets a full-depth image reach addr == N without wrapping.
  assign addr_inc     = addr + (iaddr_width + 1)'(1);

  // Next-state and datapath decode; nothing moves without a byte transfer.
  always_comb begin
    state_next = state;
    n_next     = n;
    addr_next  = addr;
    csum_next  = csum;
    hi_next    = hi;
    we         = 1'b0;
    if (xfer) begin
      case (state)
        HDR_HI: begin
          n_next[15:8] = bus.rx_data;
          state_next   = HDR_LO;
        end
        HDR_LO: begin
          n_next    = n_rx;
          addr_next = '0;
          if (n_rx == 16'd0)              state_next = CSUM;
          else if ({1'b0, n_rx} > depth_n) state_next = ERROR;
          else                            state_next = DATA_HI;
        end
        DATA_HI: begin
          hi_next    = bus.rx_data;
          csum_next  = csum ^ bus.rx_data;
          state_next = DATA_LO;
        end
        DATA_LO: begin
          we         = 1'b1;
          csum_next  = csum ^ bus.rx_data;
          addr_next  = addr_inc;
          state_next = (17'(addr_inc) == {1'b0, n}) ? CSUM : DATA_HI;
        end
        CSUM: begin
          state_next = (bus.rx_data == csum) ? RUN : ERROR;
        end
        default: ;
      endcase
    end
  end

  // Loader state and registered cpu control; reset holds the cpu in reset at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= HDR_HI;
      n             <= '0;
      addr          <= '0;
      csum          <= '0;
      hi            <= '0;
      bus.cpu_reset <= 1'b1;
      bus.load_done <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      state         <= state_next;
      n             <= n_next;
      addr          <= addr_next;
      csum          <= csum_next;
      hi            <= hi_next;
      bus.cpu_reset <= (state_next != RUN);
      bus.load_done <= (state_next == RUN);
      bus.load_err  <= (state_next == ERROR);
    end
  end

  // Image write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr[iaddr_width-1:0]] <= {hi, bus.rx_data};
  end

  // Fetch port, read-first against a same-edge write, one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.idata <= '0;
    else        bus.idata <= mem[bus.iaddr];
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
  localparam int aw    = 10;
  localparam int depth = 1 << aw;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.width(16), .iaddr_width(aw)) bus ();
  imem_loader #(.width(16), .iaddr_width(aw)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: every accepted byte since reset, plus a shadow of the RAM
  logic [7:0]  rxq[$];
  logic [15:0] mem_model [depth];
  bit          mem_known [depth];
  logic [15:0] exp_idata = '0;
  bit          exp_idata_known = 1'b1;

  bit          hold_iaddr  = 1'b0;
  logic [aw-1:0] fixed_iaddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = still loading, 1 = image accepted, 2 = image rejected
  function automatic int img_status();
    int n;
    logic [7:0] x;
    if (rxq.size() < 2) return 0;
    n = int'({rxq[0], rxq[1]});
    if (n > depth) return 2;
    if (rxq.size() < 3 + 2 * n) return 0;
    x = 8'h00;
    for (int i = 2; i < 2 + 2 * n; i++) x = x ^ rxq[i];
    return (rxq[2 + 2 * n] == x) ? 1 : 2;
  endfunction

  always @(negedge clk) begin
    if (hold_iaddr) bus.iaddr = fixed_iaddr;
    else            bus.iaddr = aw'($urandom_range(0, depth - 1));
  end

  always @(posedge clk or negedge reset) begin : model
    int k;
    int n;
    if (!reset) begin
      rxq.delete();
      exp_idata       = '0;
      exp_idata_known = 1'b1;
    end else begin
      exp_idata_known = mem_known[bus.iaddr];
      exp_idata       = mem_model[bus.iaddr];
      if (bus.rx_valid && img_status() == 0) begin
        k = rxq.size();
        if (k >= 3 && (k % 2) == 1) begin
          n = int'({rxq[0], rxq[1]});
          if ((k - 3) / 2 < n) begin
            mem_model[(k - 3) / 2] = {rxq[k - 1], bus.rx_data};
            mem_known[(k - 3) / 2] = 1'b1;
          end
        end
        rxq.push_back(bus.rx_data);
      end
    end
  end

  always @(posedge clk) begin : compare
    int st;
    #3;
    st = img_status();
    check("rx_ready",  32'(bus.rx_ready),  32'(st == 0));
    check("cpu_reset", 32'(bus.cpu_reset), 32'(st != 1));
    check("load_done", 32'(bus.load_done), 32'(st == 1));
    check("load_err",  32'(bus.load_err),  32'(st == 2));
    if (exp_idata_known) check("idata", 32'(bus.idata), 32'(exp_idata));
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int w = 0; ; w++) begin
      if (bus.rx_ready) begin
        @(posedge clk);
        break;
      end
      if (w >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_timeout: byte %0h not accepted within 200 cycles", b);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_image(input logic [15:0] words[$], input logic [7:0] flip, input int gap);
    logic [7:0]  x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(words.size());
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    foreach (words[i]) begin
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
    send_byte(x ^ flip, gap);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fetch_check(input string name, input logic [aw-1:0] a, input logic [15:0] exp);
    hold_iaddr  = 1'b1;
    fixed_iaddr = a;
    repeat (3) @(negedge clk);
    check(name, 32'(bus.idata), 32'(exp));
    hold_iaddr = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] w[$];
    logic [7:0]  flip;
    int          nw;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_err",  32'(bus.load_err),  32'd0);
    check("rst_idata",     32'(bus.idata),     32'd0);
    check("rst_rx_ready",  32'(bus.rx_ready),  32'd1);
    reset = 1'b1;

    // two-word image with the correct checksum
    w = '{16'h1234, 16'hABCD};
    send_image(w, 8'h00, 0);
    @(negedge clk);
    check("t1_csum_byte",  32'(rxq[6]),        32'h40);
    check("t1_cpu_reset",  32'(bus.cpu_reset), 32'd0);
    check("t1_load_done",  32'(bus.load_done), 32'd1);
    check("t1_rx_ready",   32'(bus.rx_ready),  32'd0);
    fetch_check("t1_word1", 10'd1, 16'hABCD);
    fetch_check("t1_word0", 10'd0, 16'h1234);

    // same image, checksum off by one
    pulse_reset();
    send_image(w, 8'h01, 0);
    @(negedge clk);
    check("t2_load_err",  32'(bus.load_err),  32'd1);
    check("t2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("t2_rx_ready",  32'(bus.rx_ready),  32'd0);

    // oversize header rejected immediately
    pulse_reset();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("t3_load_err",  32'(bus.load_err), 32'd1);
    check("t3_rx_ready",  32'(bus.rx_ready), 32'd0);
    idle(4);
    fetch_check("t3_word0_kept", 10'd0, 16'h1234);

    // full-depth image, word i = i
    pulse_reset();
    w.delete();
    for (int i = 0; i < depth; i++) w.push_back(16'(i));
    send_image(w, 8'h00, 0);
    @(negedge clk);
    check("t4_csum_byte", 32'(rxq[2 + 2 * depth]), 32'h00);
    check("t4_load_done", 32'(bus.load_done), 32'd1);
    fetch_check("t4_top", 10'h3FF, 16'h03FF);
    fetch_check("t4_bottom", 10'h000, 16'h0000);

    // empty image with gapped valid, then bytes offered in RUN
    pulse_reset();
    w.delete();
    send_image(w, 8'h00, 4);
    @(negedge clk);
    check("t5_load_done", 32'(bus.load_done), 32'd1);
    check("t5_transfers", 32'(rxq.size()), 32'd3);
    repeat (10) begin
      @(negedge clk);
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
    end
    idle(2);
    check("t5_still_run", 32'(bus.load_done), 32'd1);
    check("t5_no_extra",  32'(rxq.size()), 32'd3);

    // asynchronous reset in the middle of the payload
    pulse_reset();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("t6_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("t6_load_done", 32'(bus.load_done), 32'd0);
    check("t6_rx_ready",  32'(bus.rx_ready),  32'd1);
    check("t6_idata",     32'(bus.idata),     32'd0);
    reset = 1'b1;
    w = '{16'hBEEF, 16'h0102, 16'hF00D, 16'h7A5C};
    send_image(w, 8'h00, 3);
    @(negedge clk);
    check("t6_reload_done", 32'(bus.load_done), 32'd1);
    fetch_check("t6_word2", 10'd2, 16'hF00D);

    // random images, some with a corrupted checksum
    repeat (6) begin
      pulse_reset();
      w.delete();
      nw = $urandom_range(1, 24);
      for (int i = 0; i < nw; i++) w.push_back(16'($urandom));
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_image(w, flip, 3);
      idle(3);
      check("rnd_done", 32'(bus.load_done), 32'(flip == 8'h00));
      check("rnd_err",  32'(bus.load_err),  32'(flip != 8'h00));
    end

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
